// File: rtl/tile_map_ctrl.sv
// tile_map_ctrl: owns the 20x15 map of tile numbers behind the VGA renderer.
// One registered tile lookup per pixel clock on the read side; the single
// write port is shared by a bulk-fill engine and two round-robin requesters.
module tile_map_ctrl #(
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int TW         = 4,
  parameter int TILE_SHIFT = 5,
  parameter int RESET_FILL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_start,
  input  logic [TW-1:0] fill_val,
  output logic          busy,
  output logic          fill_done,
  input  logic          req0_valid,
  input  logic [4:0]    req0_x,
  input  logic [3:0]    req0_y,
  input  logic [TW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [4:0]    req1_x,
  input  logic [3:0]    req1_y,
  input  logic [TW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          valid,
  output logic [TW-1:0] pix_tile
);

  localparam int            DEPTH     = COLS * ROWS;
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [TW-1:0] RESET_VAL = TW'(RESET_FILL);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] fill_cnt_reg, fill_cnt_next;
  logic [TW-1:0] fill_val_reg, fill_val_next;
  logic          last_grant_reg, last_grant_next;
  logic          fill_done_reg, fill_done_next;
  logic          fill_last;

  // Requesters gathered into arrays so the per-port decode is written once
  logic          req_valid    [2];
  logic [4:0]    req_x        [2];
  logic [3:0]    req_y        [2];
  logic [TW-1:0] req_data     [2];
  logic          req_in_range [2];
  logic [AW-1:0] req_addr     [2];
  logic [1:0]    grant;

  // Shared write port
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [TW-1:0] wr_data;

  // Read path
  logic [9:0]    tx;
  logic [9:0]    ty;
  logic          rd_hit;
  logic [AW-1:0] rd_addr;
  logic [TW-1:0] pix_tile_reg;

  logic [TW-1:0] mem [DEPTH];

  assign req_valid[0] = req0_valid;
  assign req_valid[1] = req1_valid;
  assign req_x[0]     = req0_x;
  assign req_x[1]     = req1_x;
  assign req_y[0]     = req0_y;
  assign req_y[1]     = req1_y;
  assign req_data[0]  = req0_data;
  assign req_data[1]  = req1_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      // A granted write outside the map is acknowledged but never reaches memory
      assign req_in_range[gi] = (req_x[gi] < 5'(COLS)) && (req_y[gi] < 4'(ROWS));
      assign req_addr[gi]     = AW'(req_y[gi]) * AW'(COLS) + AW'(req_x[gi]);
    end
  endgenerate

  assign fill_last  = (fill_cnt_reg == LAST_ADDR);
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign fill_done  = fill_done_reg;
  assign pix_tile   = pix_tile_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: fill runs to the last address, a command restarts it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL: begin
        if (fill_last) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (fill_start) begin
          state_next = ST_FILL;
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Outputs: busy, round-robin grants and the write-port mux
  always_comb begin
    busy    = 1'b0;
    grant   = 2'b00;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (rst) begin
      // Abort whatever is in flight: no grant, no write at this edge
      busy = 1'b1;
    end else begin
      case (state_reg)
        ST_FILL: begin
          busy    = 1'b1;
          wr_en   = 1'b1;
          wr_addr = fill_cnt_reg;
          wr_data = fill_val_reg;
        end
        ST_IDLE: begin
          // A fill command takes the cycle; requesters wait
          if (!fill_start) begin
            if (req_valid[0] && req_valid[1]) begin
              grant = last_grant_reg ? 2'b01 : 2'b10;
            end else if (req_valid[0]) begin
              grant = 2'b01;
            end else if (req_valid[1]) begin
              grant = 2'b10;
            end
            if (grant[0] && req_in_range[0]) begin
              wr_en   = 1'b1;
              wr_addr = req_addr[0];
              wr_data = req_data[0];
            end else if (grant[1] && req_in_range[1]) begin
              wr_en   = 1'b1;
              wr_addr = req_addr[1];
              wr_data = req_data[1];
            end
          end
        end
        default: busy = 1'b1;
      endcase
    end
  end

  // Datapath next values: fill address/value, last grant, done pulse
  always_comb begin
    fill_cnt_next   = fill_cnt_reg;
    fill_val_next   = fill_val_reg;
    last_grant_next = last_grant_reg;
    fill_done_next  = 1'b0;
    case (state_reg)
      ST_FILL: begin
        fill_cnt_next  = fill_last ? '0 : fill_cnt_reg + 1'b1;
        fill_done_next = fill_last;
      end
      ST_IDLE: begin
        if (fill_start) begin
          fill_cnt_next = '0;
          fill_val_next = fill_val;
        end else if (grant[0]) begin
          last_grant_next = 1'b0;
        end else if (grant[1]) begin
          last_grant_next = 1'b1;
        end
      end
      default: fill_cnt_next = '0;
    endcase
  end

  // Datapath registers; last_grant starts at 1 so req0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_reg   <= '0;
      fill_val_reg   <= RESET_VAL;
      last_grant_reg <= 1'b1;
      fill_done_reg  <= 1'b0;
    end else begin
      fill_cnt_reg   <= fill_cnt_next;
      fill_val_reg   <= fill_val_next;
      last_grant_reg <= last_grant_next;
      fill_done_reg  <= fill_done_next;
    end
  end

  // Pixel to tile address; anything outside the visible map reads as tile 0
  assign tx      = h_cnt >> TILE_SHIFT;
  assign ty      = v_cnt >> TILE_SHIFT;
  assign rd_hit  = valid && (tx < 10'(COLS)) && (ty < 10'(ROWS));
  assign rd_addr = rd_hit ? (AW'(ty) * AW'(COLS) + AW'(tx)) : '0;

  // Map write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; same-address write on the same edge returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_tile_reg <= '0;
    end else begin
      pix_tile_reg <= rd_hit ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_tile_map_ctrl.sv
// tb_tile_map_ctrl: directed bench for tile_map_ctrl with a 300-entry
// reference map kept alongside the design.
module tb_tile_map_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fill_start;
  logic [3:0] fill_val;
  logic       busy;
  logic       fill_done;
  logic       req0_valid;
  logic [4:0] req0_x;
  logic [3:0] req0_y;
  logic [3:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [4:0] req1_x;
  logic [3:0] req1_y;
  logic [3:0] req1_data;
  logic       req1_ready;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic [3:0] pix_tile;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [3:0] model [300];

  always #5 clk = ~clk;

  tile_map_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_val   (fill_val),
    .busy       (busy),
    .fill_done  (fill_done),
    .req0_valid (req0_valid),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid      (valid),
    .pix_tile   (pix_tile)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_fill(input logic [3:0] v);
    for (int i = 0; i < 300; i++) model[i] = v;
  endtask

  // Called at a negedge; presents one pixel and checks it one cycle later
  task automatic read_chk(input string tag, input int h, input int v, input logic vld,
                          input logic [3:0] exp);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    valid = vld;
    @(negedge clk);
    check(tag, 32'(pix_tile), 32'(exp));
  endtask

  // One pixel from inside each tile, with the in-tile offset varied per tile
  task automatic verify_map(input string tag, input logic vld);
    for (int t = 0; t < 300; t++) begin
      read_chk($sformatf("%s[%0d]", tag, t), (t % 20) * 32 + (t * 7) % 32,
               (t / 20) * 32 + (t * 3) % 32, vld, vld ? model[t] : 4'd0);
    end
    valid = 1'b0;
    $display("txn scan %s valid=%0d tiles=300", tag, vld);
  endtask

  // Called at the negedge just after the fill began; returns at the first idle negedge
  task automatic wait_fill(input string tag, input bit poke);
    int n = 0;
    bit saw_ready = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      if (busy && (req0_ready || req1_ready)) saw_ready = 1;
      if (poke && n == 100) begin
        fill_start = 1'b1;
        fill_val   = 4'd2;
      end
      if (poke && n == 101) fill_start = 1'b0;
    end
    check({tag, "_cycles"}, 32'(n), 32'd300);
    check({tag, "_done_pulse"}, 32'(fill_done), 32'd1);
    check({tag, "_no_grant"}, 32'(saw_ready), 32'd0);
    $display("txn fill %s cycles=%0d", tag, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fill_start = 1'b0; fill_val = 4'd0;
    req0_valid = 1'b1; req0_x = 5'd0; req0_y = 4'd0; req0_data = 4'd0;
    req1_valid = 1'b1; req1_x = 5'd1; req1_y = 4'd0; req1_data = 4'd0;
    h_cnt = 10'd0; v_cnt = 10'd0; valid = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_pix", 32'(pix_tile), 32'd0);

    // Post-reset fill
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; valid = 1'b0;
    wait_fill("por", 1'b0);
    model_fill(4'd1);
    @(negedge clk);
    check("por_done_fall", 32'(fill_done), 32'd0);
    verify_map("por_v1", 1'b1);
    verify_map("por_v0", 1'b0);
    read_chk("oob_h", 700, 100, 1'b1, 4'd0);
    read_chk("oob_v", 100, 500, 1'b1, 4'd0);
    read_chk("corner", 639, 479, 1'b1, 4'd1);

    // Contention: req0 wins the first tie after reset, then alternate
    req0_valid = 1'b1; req0_x = 5'd2; req0_y = 4'd1;
    req1_valid = 1'b1; req1_x = 5'd5; req1_y = 4'd6;
    for (int k = 0; k < 4; k++) begin
      req0_data = 4'(10 + k);
      req1_data = 4'(2 + k);
      #1;
      check($sformatf("tie%0d_ready0", k), 32'(req0_ready), 32'((k % 2) == 0));
      check($sformatf("tie%0d_ready1", k), 32'(req1_ready), 32'((k % 2) == 1));
      $display("txn tie %0d ready0=%0d ready1=%0d", k, req0_ready, req1_ready);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    model[1 * 20 + 2] = 4'd12;
    model[6 * 20 + 5] = 4'd5;
    read_chk("tie_addr0", 2 * 32 + 4, 1 * 32 + 4, 1'b1, 4'd12);
    read_chk("tie_addr1", 5 * 32 + 9, 6 * 32 + 9, 1'b1, 4'd5);

    // Single write at the last tile
    req0_valid = 1'b1; req0_x = 5'd19; req0_y = 4'd14; req0_data = 4'd7;
    #1;
    check("wr_ready0", 32'(req0_ready), 32'd1);
    check("wr_ready1", 32'(req1_ready), 32'd0);
    $display("txn write req0 x=19 y=14 data=7 ready=%0d", req0_ready);
    @(negedge clk);
    req0_valid = 1'b0;
    model[299] = 4'd7;
    read_chk("wr_read", 620, 470, 1'b1, 4'd7);

    // Read and write of the same tile on one edge returns the old value
    req0_valid = 1'b1; req0_x = 5'd0; req0_y = 4'd0; req0_data = 4'd3;
    h_cnt = 10'd5; v_cnt = 10'd5; valid = 1'b1;
    #1;
    check("rbw_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    check("rbw_old", 32'(pix_tile), 32'd1);
    req0_valid = 1'b0;
    @(negedge clk);
    check("rbw_new", 32'(pix_tile), 32'd3);
    model[0] = 4'd3;
    $display("txn write req0 x=0 y=0 data=3 read-before-write");

    // Out-of-range writes are acknowledged and dropped
    req1_valid = 1'b1; req1_x = 5'd20; req1_y = 4'd3; req1_data = 4'd5;
    #1;
    check("oor_ready1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_x = 5'd0; req0_y = 4'd15; req0_data = 4'd5;
    #1;
    check("oor_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    $display("txn write out-of-range x=20,y=3 and x=0,y=15");
    verify_map("oor", 1'b1);

    // Fill command beats a simultaneous request
    fill_start = 1'b1; fill_val = 4'd9;
    req0_valid = 1'b1; req0_x = 5'd1; req0_y = 4'd1; req0_data = 4'd4;
    #1;
    check("cmd_ready0", 32'(req0_ready), 32'd0);
    @(negedge clk);
    fill_start = 1'b0; fill_val = 4'd0;
    check("cmd_busy", 32'(busy), 32'd1);
    wait_fill("cmd", 1'b1);
    model_fill(4'd9);
    check("cmd_first_idle_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("cmd_done_fall", 32'(fill_done), 32'd0);
    model[21] = 4'd4;
    verify_map("cmd", 1'b1);

    // Reset in the middle of a commanded fill
    fill_start = 1'b1; fill_val = 4'd6;
    @(negedge clk);
    fill_start = 1'b0;
    repeat (148) @(negedge clk);
    read_chk("partial_fill", 0, 0, 1'b1, 4'd6);
    rst = 1'b1;
    req1_valid = 1'b1; req1_x = 5'd3; req1_y = 4'd3; req1_data = 4'd8;
    h_cnt = 10'd0; v_cnt = 10'd0; valid = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_ready1", 32'(req1_ready), 32'd0);
    check("midrst_pix", 32'(pix_tile), 32'd0);
    check("midrst_fill_done", 32'(fill_done), 32'd0);
    rst = 1'b0; req1_valid = 1'b0; valid = 1'b0;
    $display("txn reset mid-fill");
    wait_fill("midrst", 1'b0);
    model_fill(4'd1);
    @(negedge clk);
    verify_map("midrst", 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
